// File: rtl/ir_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry circular buffer of
// {word, pc}; head entry and its LC-3b register fields are presented to decode.
module ir_queue #(
   parameter int WIDTH    = 16,
   parameter int PC_WIDTH = 16,
   parameter int DEPTH    = 4,
   parameter int CW       = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   input  logic [WIDTH-1:0]    in,
   input  logic [PC_WIDTH-1:0] in_pc,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    instruction,
   output logic [PC_WIDTH-1:0] pc,
   output logic [2:0]          dest,
   output logic [2:0]          src1,
   output logic [2:0]          src2,
   output logic [CW-1:0]       count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0]    word_mem_q [DEPTH];
   logic [PC_WIDTH-1:0] pc_mem_q   [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic push, pop;

   // Handshakes depend only on the registered occupancy.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage carries no reset; slots are only read while counted valid.
   always_ff @(posedge clk) begin
      if (push && !reset && !flush) begin
         word_mem_q[wr_ptr_q] <= in;
         pc_mem_q[wr_ptr_q]   <= in_pc;
      end
   end

   assign instruction = out_valid ? word_mem_q[rd_ptr_q] : '0;
   assign pc          = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
   assign dest        = instruction[11:9];
   assign src1        = instruction[8:6];
   assign src2        = instruction[2:0];
   assign count       = count_q;

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ir_queue;

   localparam int WIDTH    = 16;
   localparam int PC_WIDTH = 16;
   localparam int DEPTH    = 4;
   localparam int CW       = $clog2(DEPTH + 1);

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                flush = 1'b0;
   logic                in_valid = 1'b0;
   logic [WIDTH-1:0]    in_w = '0;
   logic [PC_WIDTH-1:0] in_pc = '0;
   logic                in_ready;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [WIDTH-1:0]    instruction;
   logic [PC_WIDTH-1:0] pc;
   logic [2:0]          dest, src1, src2;
   logic [CW-1:0]       count;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   typedef struct {
      logic [WIDTH-1:0]    w;
      logic [PC_WIDTH-1:0] p;
   } ent_t;
   ent_t mq[$];

   ir_queue #(.WIDTH(WIDTH), .PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in(in_w), .in_pc(in_pc), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .instruction(instruction), .pc(pc),
      .dest(dest), .src1(src1), .src2(src2), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: reset/flush empty the queue; otherwise push if not full
   // (judged before this edge's pop) and pop if non-empty.
   always @(posedge clk) begin
      bit do_push, do_pop;
      do_push = in_valid && (mq.size() != DEPTH);
      do_pop  = out_ready && (mq.size() != 0);
      if (reset || flush) begin
         mq.delete();
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back('{w: in_w, p: in_pc});
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [WIDTH-1:0]    ew;
         logic [PC_WIDTH-1:0] ep;
         ew = (mq.size() != 0) ? mq[0].w : '0;
         ep = (mq.size() != 0) ? mq[0].p : '0;
         check("m_count", 32'(count), 32'(mq.size()));
         check("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
         check("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
         check("m_instruction", 32'(instruction), 32'(ew));
         check("m_pc", 32'(pc), 32'(ep));
         check("m_dest", 32'(dest), (32'(ew) >> 9) % 8);
         check("m_src1", 32'(src1), (32'(ew) >> 6) % 8);
         check("m_src2", 32'(src2), 32'(ew) % 8);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [WIDTH-1:0] w, input logic [PC_WIDTH-1:0] p);
      in_valid = 1'b1; in_w = w; in_pc = p;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      step();
      flush = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] fill_w [4];
      fill_w[0] = 16'h1240; fill_w[1] = 16'h3A85; fill_w[2] = 16'h5DC2; fill_w[3] = 16'h7FFF;

      // Reset held 2 cycles with a push offered
      reset = 1'b1; in_valid = 1'b1; in_w = 16'hBEEF; in_pc = 16'h0010;
      step(); step();
      chk_en = 1'b1;
      reset = 1'b0; in_valid = 1'b0;
      check("rst_count", 32'(count), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_instruction", 32'(instruction), 0);
      check("rst_fields", {23'd0, pc == 0, dest, src1, src2}, 32'h200);

      // Fill and drain
      for (int i = 0; i < 4; i++) push1(fill_w[i], 16'h0100 + 16'(2 * i));
      check("full_count", 32'(count), 4);
      check("full_in_ready", 32'(in_ready), 0);
      check("head_instr", 32'(instruction), 32'h1240);
      check("head_dest", 32'(dest), 1);
      check("head_src1", 32'(src1), 1);
      check("head_src2", 32'(src2), 0);
      push1(16'h0001, 16'h0F00);
      check("fifth_dropped", 32'(count), 4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_order", 32'(instruction), 32'(fill_w[i]));
         step();
      end
      out_ready = 1'b0;
      check("drain_empty_valid", 32'(out_valid), 0);
      check("drain_empty_instr", 32'(instruction), 0);

      // Streaming with pointer wrap
      push1(16'h2000, 16'h0000);
      push1(16'h2001, 16'h0002);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("stream_head", 32'(instruction), 32'h2000 + i);
         in_w = 16'h2002 + 16'(i); in_pc = 16'(2 * (i + 2));
         step();
         check("stream_count", 32'(count), 2);
      end
      in_valid = 1'b0; out_ready = 1'b0;

      // Flush mid-stream
      do_flush();
      for (int i = 0; i < 3; i++) push1(16'h4000 + 16'(i), 16'h0300);
      flush = 1'b1; in_valid = 1'b1; in_w = 16'hABCD; in_pc = 16'h0400;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_count", 32'(count), 0);
      check("flush_out_valid", 32'(out_valid), 0);
      check("flush_in_ready", 32'(in_ready), 1);
      push1(16'h1111, 16'h0500);
      check("after_flush_head", 32'(instruction), 32'h1111);

      // Full with pop: push refused, pop taken
      do_flush();
      for (int i = 0; i < 4; i++) push1(16'h5000 + 16'(i), 16'h0600);
      in_valid = 1'b1; out_ready = 1'b1; in_w = 16'h5555; in_pc = 16'h0700;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      check("fullpop_count", 32'(count), 3);
      check("fullpop_in_ready", 32'(in_ready), 1);
      check("fullpop_head", 32'(instruction), 32'h5001);

      // Empty with pop request held
      do_flush();
      out_ready = 1'b1;
      step();
      check("empty_pop_count", 32'(count), 0);
      push1(16'h6E47, 16'h0200);
      check("single_instr", 32'(instruction), 32'h6E47);
      check("single_pc", 32'(pc), 32'h0200);
      check("single_dest", 32'(dest), 7);
      check("single_src1", 32'(src1), 1);
      check("single_src2", 32'(src2), 7);
      step();
      check("single_popped", 32'(count), 0);
      out_ready = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_w      = 16'($urandom);
         in_pc     = 16'($urandom);
         flush     = ($urandom_range(0, 60) == 0);
         reset     = ($urandom_range(0, 150) == 0);
         step();
      end
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      step();
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
